// File: rtl/accum_pkg.sv
// Shared types and defaults for the serialized accumulator arbiter.
// Provides the FSM state encoding and default sizing parameters.
package accum_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ACCUM_WIDTH = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2,
        CLR  = 2'd3
    } state_t;

endpackage

// File: rtl/accum_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping. Ports: req, ptr in; one-hot winner and any_req out.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_req
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/accum_arbiter.sv
// One shared accumulator serving NUM_REQ requesters in round-robin order.
// Ports: clk, reset_l, req/req_add/clear in; gnt, busy, resp_*, accum out.
module accum_arbiter
    import accum_pkg::*;
#(
    parameter  int NUM_REQ     = DEF_NUM_REQ,
    parameter  int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ACCUM_WIDTH-1:0] req_add,
    input  logic                           clear,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           busy,
    output logic                           resp_valid,
    output logic [ID_W-1:0]                resp_id,
    output logic [ACCUM_WIDTH-1:0]         resp_accum,
    input  logic                           resp_ready,
    output logic [ACCUM_WIDTH-1:0]         accum
);

    state_t                 state;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        win_q;
    logic [ACCUM_WIDTH-1:0] op_q;
    logic [ACCUM_WIDTH-1:0] accum_q;

    logic [NUM_REQ-1:0]     win_oh;
    logic                   any_req;
    logic [ID_W-1:0]        win_idx;
    logic [ID_W-1:0]        ptr_nxt;
    logic [ACCUM_WIDTH-1:0] win_add;
    logic [ACCUM_WIDTH-1:0] sum;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .winner  (win_oh),
        .any_req (any_req)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = ID_W'(i);
            end
        end
    end

    assign win_add = req_add[int'(win_idx)*ACCUM_WIDTH +: ACCUM_WIDTH];

    // Explicit wrap so non-power-of-two NUM_REQ stays in range.
    assign ptr_nxt = (win_idx == ID_W'(NUM_REQ-1)) ?
                     '0 : win_idx + ID_W'(1);

    // Carry-out is dropped by the width of sum.
    assign sum = accum_q + op_q;

    assign accum = accum_q;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= IDLE;
            ptr        <= '0;
            win_q      <= '0;
            op_q       <= '0;
            accum_q    <= '0;
            gnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_accum <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLR;
                    end else if (any_req) begin
                        state <= ADD;
                        gnt   <= win_oh;
                        win_q <= win_idx;
                        op_q  <= win_add;
                        ptr   <= ptr_nxt;
                    end
                end
                ADD: begin
                    state      <= RESP;
                    gnt        <= '0;
                    accum_q    <= sum;
                    resp_valid <= 1'b1;
                    resp_id    <= win_q;
                    resp_accum <= sum;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                CLR: begin
                    state   <= IDLE;
                    accum_q <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_arbiter.sv
// Randomized self-checking bench for accum_arbiter against a
// high-level model (running sum plus round-robin pointer).
module tb_accum_arbiter;

    localparam int N  = 4;
    localparam int W  = 48;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           reset_l;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_add;
    logic           clear;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           resp_valid;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_accum;
    logic           resp_ready;
    logic [W-1:0]   accum;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_acc;
    int           m_ptr;

    accum_arbiter #(
        .NUM_REQ     (N),
        .ACCUM_WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .req        (req),
        .req_add    (req_add),
        .clear      (clear),
        .gnt        (gnt),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_accum (resp_accum),
        .resp_ready (resp_ready),
        .accum      (accum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand48();
        logic [W-1:0] v;
        v = {16'($urandom), 32'($urandom)};
        return v;
    endfunction

    task automatic set_add(input int i, input logic [W-1:0] v);
        req_add[i*W +: W] = v;
    endtask

    task automatic apply_reset();
        req        = '0;
        clear      = 1'b0;
        resp_ready = 1'b1;
        reset_l    = 1'b0;
        step();
        step();
        reset_l = 1'b1;
        step();
        m_acc = '0;
        m_ptr = 0;
    endtask

    // Drives one operation from IDLE with resp_ready high and reports
    // what the DUT showed; callers do their own comparisons.
    task automatic run_op(
        input  logic [N-1:0]  r,
        output logic [N-1:0]  o_gnt,
        output logic          o_vld,
        output logic [IW-1:0] o_id,
        output logic [W-1:0]  o_acc
    );
        req = r;
        step();
        o_gnt = gnt;
        step();
        o_vld = resp_valid;
        o_id  = resp_id;
        o_acc = resp_accum;
        step();
    endtask

    task automatic model_op(
        input  logic [N-1:0] r,
        output int           w
    );
        w = model_pick(r);
        if (w >= 0) begin
            m_acc = m_acc + req_add[w*W +: W];
            m_ptr = (w + 1) % N;
        end
    endtask

    task automatic test_reset();
        req        = '0;
        req_add    = '0;
        clear      = 1'b0;
        resp_ready = 1'b1;
        reset_l    = 1'b0;
        #2;
        checks++;
        if ({gnt, busy, resp_valid, resp_id, resp_accum, accum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b busy=%b vld=%b acc=%h want 0",
                     gnt, busy, resp_valid, accum);
        end
        step();
        reset_l = 1'b1;
        step();
        m_acc = '0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        apply_reset();
        set_add(0, 48'h10);
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b busy=%b want 0001/1", gnt, busy);
        end
        req = '0;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 ||
            resp_accum !== 48'h10 || gnt !== '0) begin
            errors++;
            $display("FAIL single_resp: vld=%b id=%0d acc=%h gnt=%b want 1/0/10/0",
                     resp_valid, resp_id, resp_accum, gnt);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || accum !== 48'h10) begin
            errors++;
            $display("FAIL single_done: vld=%b busy=%b acc=%h want 0/0/10",
                     resp_valid, busy, accum);
        end
        m_acc = 48'h10;
        m_ptr = 1;
    endtask

    task automatic test_round_robin();
        int           exp_id [5];
        logic [W-1:0] exp_acc [5];
        logic [N-1:0] og;
        logic         ov;
        logic [IW-1:0] oi;
        logic [W-1:0] oa;
        exp_id  = '{0, 1, 2, 3, 0};
        exp_acc = '{48'd1, 48'd3, 48'd6, 48'd10, 48'd11};
        apply_reset();
        for (int i = 0; i < N; i++) set_add(i, W'(i + 1));
        for (int k = 0; k < 5; k++) begin
            run_op(4'b1111, og, ov, oi, oa);
            checks++;
            if (og !== (4'b0001 << exp_id[k]) || ov !== 1'b1 ||
                oi !== IW'(exp_id[k]) || oa !== exp_acc[k]) begin
                errors++;
                $display("FAIL rr_op%0d: gnt=%b id=%0d acc=%0d want id=%0d acc=%0d",
                         k, og, oi, oa, exp_id[k], exp_acc[k]);
            end
        end
        req = '0;
        m_acc = 48'd11;
        m_ptr = 1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || gnt !== '0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_state: busy=%b gnt=%b vld=%b want 1/0/0",
                     busy, gnt, resp_valid);
        end
        clear = 1'b0;
        step();
        m_acc = '0;
    endtask

    task automatic test_wrap();
        logic [N-1:0] og;
        logic         ov;
        logic [IW-1:0] oi;
        logic [W-1:0] oa;
        do_clear();
        set_add(1, 48'hFFFF_FFFF_FFFF);
        run_op(4'b0010, og, ov, oi, oa);
        req = '0;
        checks++;
        if (oa !== 48'hFFFF_FFFF_FFFF || accum !== 48'hFFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: acc=%h want ffffffffffff", accum);
        end
        set_add(3, 48'h2);
        run_op(4'b1000, og, ov, oi, oa);
        req = '0;
        checks++;
        if (og !== 4'b1000 || oi !== 2'd3 || oa !== 48'h1 || accum !== 48'h1) begin
            errors++;
            $display("FAIL wrap_sum: gnt=%b id=%0d acc=%h want 1000/3/1",
                     og, oi, oa);
        end
        m_acc = 48'h1;
        m_ptr = 0;
    endtask

    task automatic test_backpressure();
        int           w;
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) set_add(i, rand48());
        model_op(4'b0110, w);
        v = m_acc;
        resp_ready = 1'b0;
        req = 4'b0110;
        step();
        checks++;
        if (gnt !== (4'b0001 << w)) begin
            errors++;
            $display("FAIL bp_gnt: gnt=%b want %b", gnt, 4'b0001 << w);
        end
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== IW'(w) ||
                resp_accum !== v || gnt !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b id=%0d acc=%h gnt=%b busy=%b want id=%0d acc=%h",
                         c, resp_valid, resp_id, resp_accum, gnt, busy, w, v);
            end
            step();
        end
        resp_ready = 1'b1;
        req = '0;
        step();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || accum !== v) begin
            errors++;
            $display("FAIL bp_release: vld=%b busy=%b acc=%h want 0/0/%h",
                     resp_valid, busy, accum, v);
        end
    endtask

    task automatic test_clear_priority();
        logic [N-1:0] og;
        logic         ov;
        logic [IW-1:0] oi;
        logic [W-1:0] oa;
        do_clear();
        set_add(0, 48'h50);
        m_ptr = 0;
        apply_reset();
        run_op(4'b0001, og, ov, oi, oa);
        req = '0;
        checks++;
        if (accum !== 48'h50) begin
            errors++;
            $display("FAIL clrp_pre: acc=%h want 50", accum);
        end
        set_add(2, 48'h7);
        clear = 1'b1;
        req = 4'b0100;
        step();
        checks++;
        if (busy !== 1'b1 || gnt !== '0) begin
            errors++;
            $display("FAIL clrp_first: busy=%b gnt=%b want 1/0000", busy, gnt);
        end
        step();
        clear = 1'b0;
        checks++;
        if (accum !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clrp_zero: acc=%h busy=%b want 0/0", accum, busy);
        end
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL clrp_gnt: gnt=%b want 0100", gnt);
        end
        req = '0;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_accum !== 48'h7) begin
            errors++;
            $display("FAIL clrp_resp: vld=%b id=%0d acc=%h want 1/2/7",
                     resp_valid, resp_id, resp_accum);
        end
        step();
        m_acc = 48'h7;
        m_ptr = 3;
    endtask

    task automatic test_reset_mid_op();
        logic [N-1:0] og;
        logic         ov;
        logic [IW-1:0] oi;
        logic [W-1:0] oa;
        logic         seen;
        for (int i = 0; i < N; i++) set_add(i, rand48());
        req = 4'b0010;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rst_pre: gnt=%b want 0010", gnt);
        end
        #2;
        reset_l = 1'b0;
        req = '0;
        #1;
        checks++;
        if ({gnt, busy, resp_valid, resp_id, resp_accum, accum} !== '0) begin
            errors++;
            $display("FAIL rst_async: gnt=%b busy=%b vld=%b acc=%h want 0",
                     gnt, busy, resp_valid, accum);
        end
        step();
        reset_l = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp_valid || gnt != '0 || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resp: activity=%b want 0", seen);
        end
        m_acc = '0;
        m_ptr = 0;
        run_op(4'b1111, og, ov, oi, oa);
        req = '0;
        checks++;
        if (og !== 4'b0001 || oa !== req_add[W-1:0]) begin
            errors++;
            $display("FAIL rst_ptr: gnt=%b acc=%h want 0001/%h",
                     og, oa, req_add[W-1:0]);
        end
        m_acc = req_add[W-1:0];
        m_ptr = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] og;
        logic         ov;
        logic [IW-1:0] oi;
        logic [W-1:0] oa;
        logic [N-1:0] r;
        int           w;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_clear();
                checks++;
                if (accum !== '0) begin
                    errors++;
                    $display("FAIL rnd_clear%0d: acc=%h want 0", k, accum);
                end
            end else begin
                for (int i = 0; i < N; i++) set_add(i, rand48());
                r = N'($urandom_range(1, (1 << N) - 1));
                model_op(r, w);
                run_op(r, og, ov, oi, oa);
                req = '0;
                checks++;
                if (og !== (4'b0001 << w) || ov !== 1'b1 ||
                    oi !== IW'(w) || oa !== m_acc || accum !== m_acc) begin
                    errors++;
                    $display("FAIL rnd_op%0d: req=%b gnt=%b id=%0d acc=%h want id=%0d acc=%h",
                             k, r, og, oi, oa, w, m_acc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_clear_priority();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_arbiter.md
Name: accum_arbiter

Overview:
- Shares one ACCUM_WIDTH-bit running accumulator among NUM_REQ requesters.
- Requesters raise req with an operand. A round-robin arbiter selects one request at a time, adds its operand to the shared accumulator, and returns the new sum tagged with the requester id.
- Sits between software-driven test harness ports and the accumulation datapath. It replaces per-requester accumulators with a single serialized resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ACCUM_WIDTH, 48, accumulator and operand width in bits.
- ID_W, $clog2(NUM_REQ), requester id width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset_l  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request; held high until matching gnt bit.
- req_add  in  NUM_REQ*ACCUM_WIDTH  packed operands; requester i at bits [i*W +: W]; stable while req[i] high.
- clear  in  1  synchronous accumulator clear request.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: operand of that requester accepted.
- busy  out  1  high in any state other than IDLE.
- resp_valid  out  1  result available.
- resp_id  out  ID_W  requester id of the result.
- resp_accum  out  ACCUM_WIDTH  accumulator value after the granted add.
- resp_ready  in  1  consumer accepts the result.
- accum  out  ACCUM_WIDTH  live accumulator value.

Behaviour:
- Reset values (async, on reset_l low): all outputs 0; accumulator 0; state IDLE; round-robin pointer 0. Reset asserted mid-operation aborts the operation; no gnt or resp is produced for it.
- FSM states:
  - IDLE -> CLR if clear high (clear beats req).
  - IDLE -> ADD if any req bit is high.
  - ADD -> RESP after exactly one cycle.
  - RESP -> IDLE when resp_valid && resp_ready.
  - CLR -> IDLE after one cycle.
- Arbitration (evaluated in IDLE only):
  - Winner = first set req bit at or above the pointer, wrapping modulo NUM_REQ.
  - Winner index and operand are latched on the IDLE->ADD edge.
  - Pointer <= (winner+1) mod NUM_REQ on the same edge.
- ADD cycle:
  - gnt[winner]=1 for exactly this cycle.
  - accumulator <= accumulator + operand, truncated modulo 2^ACCUM_WIDTH; carry-out is discarded.
- RESP state:
  - resp_valid=1; resp_id and resp_accum are stable until the handshake completes.
  - resp_valid drops the cycle after the handshake.
- Latency and throughput:
  - From req sampled in IDLE to gnt: 1 cycle.
  - From req sampled in IDLE to resp_valid: 2 cycles.
  - Minimum 3 cycles per operation with resp_ready tied high.
- CLR state: accumulator <= 0. No resp is produced.
- Timing of clear: clear is sampled only in IDLE. If clear is high in other states it is ignored; the source holds it until busy is low.
- Requester rules:
  - A req bit dropped before its gnt is simply not served.
  - The operand read is the value present on the IDLE sampling edge.
- Back-to-back requests: the same requester cannot win twice in a row while another req is pending. Fairness bound: any continuously asserted req is granted within NUM_REQ operations.
- Simultaneous events:
  - clear and req together in IDLE: CLR first, then the req is served.
  - req changes during ADD/RESP: no effect until the next IDLE.
- accum output mirrors the accumulator register at all times.
- busy = (state != IDLE).

Decomposition:
- Shared package accum_pkg:
  - state enum (IDLE, ADD, RESP, CLR) as 2-bit logic.
  - Default ACCUM_WIDTH and NUM_REQ localparams.
- Sub-module rr_arbiter, parameterized by NUM_REQ:
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner and any_req; combinational.
  - Pointer register stays in the parent.

Test Plan:
- Single requester: reset, ACCUM_WIDTH=48, req[0] with add=0x10 -> gnt[0] one cycle later; resp_valid 2 cycles after sampling; resp_id=0, resp_accum=0x10.
- Round-robin: all 4 req held, add_i=i+1, resp_ready=1 -> grant order 0,1,2,3,0; resp_accum 1,3,6,10,11.
- Wrap-around: accumulator preloaded via adds to 0xFFFF_FFFF_FFFF, add 0x2 -> resp_accum=0x1.
- Backpressure: resp_ready low 5 cycles -> resp_valid, resp_id, resp_accum stable; no new gnt; busy=1 throughout.
- Clear priority: accum=0x50, clear and req[2] (add=0x7) in the same IDLE cycle -> accum=0 after CLR, then resp_accum=0x7, resp_id=2.
- Reset mid-op: reset_l low during ADD -> all outputs 0 immediately; after release no resp for the aborted request; pointer=0.
